// File: rtl/ram32x4_arbiter.sv
// Round-robin two-port sequencer for the registered single-port ram32x4.
// Define RAM_CLEAR_EN to zero the whole RAM after every reset.
module ram32x4_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    CLEAR
  } state_t;

`ifdef RAM_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t state_q, state_d;

  // owner/last_owner: 0 = A, 1 = B
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic win_b;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              wren_d;
  logic              gnt_a_d, gnt_b_d;
  logic              rv_a_d, rv_b_d;
  logic [DATA_W-1:0] rd_a_d, rd_b_d;

`ifdef RAM_CLEAR_EN
  logic            busy_q, busy_d;
  logic [ADDR_W:0] clr_q, clr_d;

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  // On a tie the port that did not win last time gets the slot.
  assign win_b = req_b & (~req_a | ~last_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = ram_addr;
    data_d  = ram_data;
    wren_d  = 1'b0;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    rv_a_d  = 1'b0;
    rv_b_d  = 1'b0;
    rd_a_d  = rdata_a;
    rd_b_d  = rdata_b;
`ifdef RAM_CLEAR_EN
    busy_d  = busy_q;
    clr_d   = clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          owner_d = win_b;
          last_d  = win_b;
          gnt_a_d = ~win_b;
          gnt_b_d = win_b;
          addr_d  = win_b ? addr_b : addr_a;
          data_d  = win_b ? wdata_b : wdata_a;
          wren_d  = win_b ? we_b : we_a;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // ram_wren still shows the kind of command the RAM just took.
        state_d = ram_wren ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (owner_q) begin
          rv_b_d = 1'b1;
          rd_b_d = ram_q;
        end else begin
          rv_a_d = 1'b1;
          rd_a_d = ram_q;
        end
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        if (clr_q[ADDR_W]) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          addr_d = clr_q[ADDR_W-1:0];
          data_d = '0;
          wren_d = 1'b1;
          clr_d  = clr_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RST_ST;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      ram_addr <= addr_d;
      ram_data <= data_d;
      ram_wren <= wren_d;
      gnt_a    <= gnt_a_d;
      gnt_b    <= gnt_b_d;
      rvalid_a <= rv_a_d;
      rvalid_b <= rv_b_d;
      rdata_a  <= rd_a_d;
      rdata_b  <= rd_b_d;
    end
  end

`ifdef RAM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      clr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      clr_q  <= clr_d;
    end
  end
`endif

endmodule
